// File: rtl/brc_unit.sv
// Registered branch comparator: equality and signed/unsigned less-than of rs1 vs rs2.
// Both flags are captured in the same flop stage so they always describe one operand sample.
module brc_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_br_un,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_brc_less,
    output logic                  o_brc_equal
);

    logic less_d, less_q;
    logic equal_d, equal_q;
    logic msb_diff;
    logic low_lt;

    always_comb begin
        equal_d  = (i_rs1_data == i_rs2_data);
        msb_diff = i_rs1_data[DATA_WIDTH-1] ^ i_rs2_data[DATA_WIDTH-1];
        low_lt   = (i_rs1_data[DATA_WIDTH-2:0] < i_rs2_data[DATA_WIDTH-2:0]);
        // With differing MSBs the negative (signed) or smaller (unsigned) side is decided by the MSB alone.
        if (msb_diff) begin
            less_d = i_br_un ? i_rs2_data[DATA_WIDTH-1] : i_rs1_data[DATA_WIDTH-1];
        end else begin
            less_d = low_lt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            less_q  <= less_d;
            equal_q <= equal_d;
        end
    end

    assign o_brc_less  = less_q;
    assign o_brc_equal = equal_q;

endmodule

// File: tb/tb_brc_unit.sv
// Self-checking bench for brc_unit: directed boundary cases plus a randomized sweep
// against an arithmetic reference model.
module tb_brc_unit;

    logic        clk;
    logic        rst;
    logic        br_un;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        less;
    logic        equal;

    int checks;
    int failures;

    brc_unit #(.DATA_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_br_un     (br_un),
        .i_rs1_data  (rs1),
        .i_rs2_data  (rs2),
        .o_brc_less  (less),
        .o_brc_equal (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_less(input logic [31:0] a, input logic [31:0] b, input logic un);
        longint sa, sb;
        longint unsigned ua, ub;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return un ? (ua < ub) : (sa < sb);
    endfunction

    // Present inputs, take one rising edge, and leave the bench 1 time unit past it.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic un, input logic r);
        rs1   = a;
        rs2   = b;
        br_un = un;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(32'd5, 32'd5, 1'b0, 1'b1);
            checks++;
            if (less !== 1'b0) begin
                failures++;
                $display("FAIL reset_less edge%0d got=%b exp=0", i, less);
            end
            checks++;
            if (equal !== 1'b0) begin
                failures++;
                $display("FAIL reset_equal edge%0d got=%b exp=0", i, equal);
            end
        end
        drive(32'd5, 32'd5, 1'b0, 1'b0);
        checks++;
        if (equal !== 1'b1) begin
            failures++;
            $display("FAIL release_equal got=%b exp=1", equal);
        end
        checks++;
        if (less !== 1'b0) begin
            failures++;
            $display("FAIL release_less got=%b exp=0", less);
        end
    endtask

    task automatic test_equal_mode();
        for (int m = 0; m < 2; m++) begin
            drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, m[0], 1'b0);
            checks++;
            if (equal !== 1'b1) begin
                failures++;
                $display("FAIL eq_mode%0d_equal got=%b exp=1", m, equal);
            end
            checks++;
            if (less !== 1'b0) begin
                failures++;
                $display("FAIL eq_mode%0d_less got=%b exp=0", m, less);
            end
        end
    endtask

    task automatic test_sign_boundary();
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001;
        ta[1] = 32'h8000_0000; tb[1] = 32'h7FFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                drive(ta[i], tb[i], m[0], 1'b0);
                // Negative-looking A is less when signed, greater when unsigned.
                checks++;
                if (less !== (m == 0)) begin
                    failures++;
                    $display("FAIL sign_bnd%0d_mode%0d_less got=%b exp=%b", i, m, less, (m == 0));
                end
                checks++;
                if (equal !== 1'b0) begin
                    failures++;
                    $display("FAIL sign_bnd%0d_mode%0d_equal got=%b exp=0", i, m, equal);
                end
            end
        end
    endtask

    task automatic test_same_sign();
        logic [31:0] lo [2];
        logic [31:0] hi [2];
        lo[0] = 32'd2;         hi[0] = 32'd3;
        lo[1] = 32'hFFFF_FFFE; hi[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                for (int s = 0; s < 2; s++) begin
                    if (s == 0) drive(lo[i], hi[i], m[0], 1'b0);
                    else        drive(hi[i], lo[i], m[0], 1'b0);
                    checks++;
                    if (less !== (s == 0)) begin
                        failures++;
                        $display("FAIL same_sign%0d_mode%0d_swap%0d_less got=%b exp=%b", i, m, s, less, (s == 0));
                    end
                    checks++;
                    if (equal !== 1'b0) begin
                        failures++;
                        $display("FAIL same_sign%0d_mode%0d_swap%0d_equal got=%b exp=0", i, m, s, equal);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic        r;
        logic        exp_l, exp_e;
        pa[0] = 32'd7;         pb[0] = 32'd7;
        pa[1] = 32'h8000_0000; pb[1] = 32'd1;
        pa[2] = 32'd1;         pb[2] = 32'd1;
        pa[3] = 32'd9;         pb[3] = 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) begin
            r = (i == 2);
            drive(pa[i], pb[i], 1'b0, r);
            exp_l = r ? 1'b0 : ref_less(pa[i], pb[i], 1'b0);
            exp_e = r ? 1'b0 : (pa[i] == pb[i]);
            checks++;
            if (less !== exp_l) begin
                failures++;
                $display("FAIL b2b%0d_less got=%b exp=%b", i, less, exp_l);
            end
            checks++;
            if (equal !== exp_e) begin
                failures++;
                $display("FAIL b2b%0d_equal got=%b exp=%b", i, equal, exp_e);
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [31:0] a, b;
        int          sa, sb;
        logic        exp_l, exp_e;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 50; i++) begin
                if (i % 2 == 0) begin
                    sa = int'($urandom_range(0, 6)) - 3;
                    sb = int'($urandom_range(0, 6)) - 3;
                    a  = sa;
                    b  = sb;
                end else begin
                    a = $urandom;
                    b = $urandom;
                end
                drive(a, b, m[0], 1'b0);
                exp_l = ref_less(a, b, m[0]);
                exp_e = (a == b);
                checks++;
                if (less !== exp_l) begin
                    failures++;
                    $display("FAIL rand_mode%0d_%0d_less a=%h b=%h got=%b exp=%b", m, i, a, b, less, exp_l);
                end
                checks++;
                if (equal !== exp_e) begin
                    failures++;
                    $display("FAIL rand_mode%0d_%0d_equal a=%h b=%h got=%b exp=%b", m, i, a, b, equal, exp_e);
                end
                checks++;
                if ((less & equal) !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_mode%0d_%0d_both_set less=%b equal=%b exp=not both 1", m, i, less, equal);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        br_un    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        #1;
        test_reset();
        test_equal_mode();
        test_sign_boundary();
        test_same_sign();
        test_back_to_back();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
